// File: rtl/sn74_pkg.sv
// Shared definitions for the '158-style nibble bus receiver.
package sn74_pkg;

   localparam int unsigned DEF_DEPTH = 4;
   localparam int unsigned WORD_W    = 8;

   typedef enum logic {
      IDLE,
      HAVE_A
   } state_t;

endpackage

// File: rtl/sn74xx158_rx_fifo.sv
// Output word FIFO for sn74xx158_rx; DEPTH must be a power of two, minimum 2.
module sn74xx158_rx_fifo
   import sn74_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [WORD_W-1:0] din,
   input  logic              pop,
   output logic [WORD_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   // a pop on the same edge frees the slot, so a push while full is still taken
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sn74xx158_rx.sv
// Receiver for a '158-style inverted, multiplexed nibble bus; rebuilds {B,A} words.
// Optional error counter enabled by defining SN74XX158_RX_ERRCNT_EN.
module sn74xx158_rx
   import sn74_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        y_n,
   input  logic              sel,
   input  logic              g_n,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              err,
   output logic              ovf,
   output logic [7:0]        err_cnt
);

   state_t            state, state_nx;
   logic [3:0]        a_q, a_nx, nib;
   logic              push, perr, oflow, pop, full, empty;
   logic [WORD_W-1:0] word;

   assign nib  = ~y_n;
   assign word = {nib, a_q};

   always_comb begin
      state_nx = state;
      a_nx     = a_q;
      push     = 1'b0;
      perr     = 1'b0;
      case (state)
         IDLE: begin
            if (!g_n) begin
               if (!sel) begin
                  a_nx     = nib;
                  state_nx = HAVE_A;
               end else begin
                  perr = 1'b1;
               end
            end
         end
         HAVE_A: begin
            if (g_n) begin
               perr     = 1'b1;
               state_nx = IDLE;
            end else if (sel) begin
               push     = 1'b1;
               state_nx = IDLE;
            end else begin
               a_nx = nib;
               perr = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign dout_valid = ~empty;
   assign pop        = dout_valid & dout_ready;
   assign oflow      = push & full & ~pop;

   sn74xx158_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (word),
      .pop   (pop),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         err   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         a_q   <= a_nx;
         err   <= perr | oflow;
         ovf   <= ovf | oflow;
      end
   end

`ifdef SN74XX158_RX_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if ((perr | oflow) && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sn74xx158_rx.sv
// Scoreboard bench for sn74xx158_rx: a behavioural model predicts words, err, ovf and err_cnt.
module tb_sn74xx158_rx;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] y_n;
   logic       sel, g_n, dout_ready;
   logic [7:0] dout, err_cnt;
   logic       dout_valid, err, ovf;

   logic [7:0]  sb[$];
   bit          m_have_a;
   logic [3:0]  m_a;
   logic        m_err, m_ovf;
   int unsigned m_cnt;
   int unsigned total, bad;

   sn74xx158_rx #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .y_n        (y_n),
      .sel        (sel),
      .g_n        (g_n),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .err        (err),
      .ovf        (ovf),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_cnt();
`ifdef SN74XX158_RX_ERRCNT_EN
      return 8'(m_cnt);
`else
      return 8'h00;
`endif
   endfunction

   // drives one bus cycle, advances the model, returns 1 ns after the edge
   task automatic drive(input logic g, input logic s, input logic [3:0] y, input logic r);
      logic [3:0] nib;
      logic [7:0] w;
      logic       perr, pushw, popping, oflow;
      g_n = g; sel = s; y_n = y; dout_ready = r;
      nib = ~y; perr = 1'b0; pushw = 1'b0; w = '0;
      if (!g) begin
         if (!m_have_a) begin
            if (!s) begin m_have_a = 1'b1; m_a = nib; end
            else perr = 1'b1;
         end else if (s) begin
            pushw = 1'b1; w = {nib, m_a}; m_have_a = 1'b0;
         end else begin
            m_a = nib; perr = 1'b1;
         end
      end else if (m_have_a) begin
         m_have_a = 1'b0; perr = 1'b1;
      end
      popping = r && (sb.size() > 0);
      oflow   = pushw && (sb.size() == DEPTH) && !popping;
      if (popping) void'(sb.pop_front());
      if (pushw && !oflow) sb.push_back(w);
      m_err = perr | oflow;
      if (oflow) m_ovf = 1'b1;
      if (m_err && m_cnt < 255) m_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      sb.delete();
      m_have_a = 1'b0; m_a = '0; m_err = 1'b0; m_ovf = 1'b0; m_cnt = 0;
   endtask

   task automatic check_flags(input string name);
      total++;
      if (err !== m_err) begin bad++; $display("FAIL %s err: got %b want %b", name, err, m_err); end
      total++;
      if (ovf !== m_ovf) begin bad++; $display("FAIL %s ovf: got %b want %b", name, ovf, m_ovf); end
      total++;
      if (err_cnt !== exp_cnt()) begin bad++; $display("FAIL %s err_cnt: got %h want %h", name, err_cnt, exp_cnt()); end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 2 * DEPTH + 4 && sb.size() > 0; i++) begin
         total++;
         if (dout_valid !== 1'b1 || dout !== sb[0]) begin
            bad++;
            $display("FAIL %s pop%0d: got v=%b d=%h want v=1 d=%h", name, i, dout_valid, dout, sb[0]);
         end
         drive(1'b1, 1'b0, 4'h0, 1'b1);
      end
      total++;
      if (sb.size() != 0 || dout_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s drain end: got v=%b left=%0d want v=0 left=0", name, dout_valid, sb.size());
      end
      dout_ready = 1'b0;
   endtask

   task automatic push_word(input logic [7:0] w, input logic r);
      drive(1'b0, 1'b0, ~w[3:0], 1'b0);
      drive(1'b0, 1'b1, ~w[7:4], r);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; g_n = 1'b1; sel = 1'b0; y_n = 4'h0; dout_ready = 1'b0;
      model_clear();
      #12;
      total++;
      if (dout_valid !== 1'b0 || dout !== 8'h00) begin
         bad++; $display("FAIL reset out: got v=%b d=%h want v=0 d=00", dout_valid, dout);
      end
      check_flags("reset");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      drive(1'b0, 1'b0, 4'h5, 1'b0);
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL basic A-only valid: got %b want 0", dout_valid); end
      drive(1'b0, 1'b1, 4'h0, 1'b0);
      total++;
      if (dout_valid !== 1'b1 || dout !== 8'hFA) begin
         bad++; $display("FAIL basic word: got v=%b d=%h want v=1 d=fa", dout_valid, dout);
      end
      check_flags("basic");
      drain("basic");
   endtask

   task automatic test_b_without_a();
      drive(1'b0, 1'b1, 4'h3, 1'b0);
      check_flags("b_no_a");
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL b_no_a push: got v=%b want 0", dout_valid); end
      drive(1'b1, 1'b0, 4'h0, 1'b0);
      check_flags("b_no_a after");
   endtask

   task automatic test_overwrite();
      drive(1'b0, 1'b0, 4'hE, 1'b0);
      drive(1'b0, 1'b0, 4'hC, 1'b0);
      check_flags("overwrite A");
      drive(1'b0, 1'b1, 4'hA, 1'b0);
      check_flags("overwrite B");
      total++;
      if (dout !== 8'h53) begin bad++; $display("FAIL overwrite word: got %h want 53", dout); end
      drain("overwrite");
   endtask

   task automatic test_abort();
      drive(1'b0, 1'b0, 4'h1, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 1'b0);
      check_flags("abort");
      drive(1'b1, 1'b0, 4'h0, 1'b0);
      check_flags("idle quiet");
   endtask

   task automatic test_full_pushpop();
      push_word(8'h11, 1'b0);
      push_word(8'h22, 1'b0);
      push_word(8'h33, 1'b0);
      push_word(8'h44, 1'b0);
      drive(1'b0, 1'b0, ~4'h5, 1'b0);
      drive(1'b0, 1'b1, ~4'h5, 1'b1);
      check_flags("full pushpop");
      dout_ready = 1'b0;
      drain("full pushpop");
   endtask

   task automatic test_overflow();
      for (int unsigned k = 1; k <= 5; k++) push_word(8'(k), 1'b0);
      check_flags("overflow");
      drain("overflow");
   endtask

   task automatic test_reset_midword();
      push_word(8'h66, 1'b0);
      push_word(8'h77, 1'b0);
      drive(1'b0, 1'b0, 4'h2, 1'b0);
      rst_n = 1'b0;
      model_clear();
      #1;
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL midreset valid: got %b want 0", dout_valid); end
      check_flags("midreset");
      g_n = 1'b1;
      #2 rst_n = 1'b1;
      drive(1'b0, 1'b1, 4'h3, 1'b0);
      check_flags("post reset B");
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL post reset push: got v=%b want 0", dout_valid); end
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset();
      test_basic();
      test_b_without_a();
      test_overwrite();
      test_abort();
      test_full_pushpop();
      test_overflow();
      test_reset_midword();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
